// File: rtl/fixed_pkg.sv
// fixed_pkg: shared Q8.24 fixed-point types, limits and the saturate-to-32 helper.
package fixed_pkg;
    localparam int FIXED_W = 32;
    localparam int FRAC_BITS = 24;
    typedef logic signed [FIXED_W-1:0] fixed_t;
    localparam fixed_t FIXED_MAX = 32'h7FFFFFFF;
    localparam fixed_t FIXED_MIN = 32'h80000000;
    typedef enum logic [1:0] {IDLE, MX, MY, MZ} dot3_state_t;
    function automatic fixed_t sat32(input logic signed [63:0] v);
        return v > 64'sh7FFFFFFF ? FIXED_MAX : v < -64'sh80000000 ? FIXED_MIN : v[31:0];
    endfunction
endpackage

// File: rtl/fixed_mul.sv
// fixed_mul: combinational Q8.24 multiply, floor shift by FRAC_BITS, optional clamp to 32 bits.
module fixed_mul #(
    parameter int FRAC_BITS = fixed_pkg::FRAC_BITS,
    parameter bit SAT = 1'b0
) (
    input  fixed_pkg::fixed_t a,
    input  fixed_pkg::fixed_t b,
    output fixed_pkg::fixed_t p
);
    import fixed_pkg::*;
    logic signed [63:0] prod;
    logic signed [63:0] sh;
    // Full-width product; >>> on a signed value truncates toward minus infinity.
    always_comb begin
        prod = 64'(a) * 64'(b);
        sh = prod >>> FRAC_BITS;
        p = SAT ? sat32(sh) : sh[31:0];
    end
endmodule

// File: rtl/fixed_dot3.sv
// fixed_dot3: sequential Q8.24 dot product r = ax*bx + ay*by + az*bz over three cycles.
// Define FIXED_DOT3_SATURATE_EN to clamp each product and the final sum; otherwise both wrap modulo 2^32.
module fixed_dot3 #(
    parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ax,
    input  logic [31:0] ay,
    input  logic [31:0] az,
    input  logic [31:0] bx,
    input  logic [31:0] by,
    input  logic [31:0] bz,
    input  logic        new_data,
    output logic [31:0] r,
    output logic        output_valid,
    output logic        busy
);
    import fixed_pkg::*;
`ifdef FIXED_DOT3_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    dot3_state_t state, state_nxt;
    logic [2:0][31:0] a_q, b_q;
    fixed_t m_a, m_b, prod;
    logic signed [33:0] acc, acc_nxt;
    logic start;
    assign busy = state != IDLE;
    assign start = state == IDLE && new_data;
    fixed_mul #(.FRAC_BITS(FRAC_BITS), .SAT(SAT)) u_mul (.a(m_a), .b(m_b), .p(prod));
    // Next state, operand-pair select and the accumulator sum for the current term.
    always_comb begin
        state_nxt = state == IDLE ? (new_data ? MX : IDLE) : state == MX ? MY : state == MY ? MZ : IDLE;
        m_a = state == MY ? a_q[1] : state == MZ ? a_q[2] : a_q[0];
        m_b = state == MY ? b_q[1] : state == MZ ? b_q[2] : b_q[0];
        acc_nxt = acc + {{2{prod[31]}}, prod};
    end
    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    // Operand capture, accumulation and result write on the last term.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            r <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= state == MZ;
            if (start) begin
                a_q <= {az, ay, ax};
                b_q <= {bz, by, bx};
                acc <= '0;
            end else if (busy) begin
                acc <= acc_nxt;
            end
            if (state == MZ) r <= SAT ? sat32(64'(acc_nxt)) : acc_nxt[31:0];
        end
    end
endmodule

// File: tb/tb_fixed_dot3.sv
// tb_fixed_dot3: randomized and directed scoreboard bench for fixed_dot3 against an arithmetic model.
module tb_fixed_dot3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic new_data = 1'b0;
    logic [2:0][31:0] va = '0, vb = '0;
    logic [31:0] r;
    logic output_valid, busy;
    int cyc = 0;
    int vecs = 0;
    int fails = 0;
    typedef struct {
        logic [31:0] r;
        int due;
    } exp_t;
    exp_t q[$];

    fixed_dot3 dut (
        .clk(clk), .rst(rst),
        .ax(va[0]), .ay(va[1]), .az(va[2]),
        .bx(vb[0]), .by(vb[1]), .bz(vb[2]),
        .new_data(new_data), .r(r), .output_valid(output_valid), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic longint fit32(input longint v);
        logic [63:0] u;
`ifdef FIXED_DOT3_SATURATE_EN
        return v > 64'sh7FFFFFFF ? 64'sh7FFFFFFF : v < -64'sh80000000 ? -64'sh80000000 : v;
`else
        u = 64'(v);
        return longint'($signed(u[31:0]));
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0][31:0] a, input logic [2:0][31:0] b);
        longint s = 0;
        longint p;
        logic [63:0] u;
        for (int i = 0; i < 3; i++) begin
            p = longint'($signed(a[i])) * longint'($signed(b[i]));
            p = p >>> 24;
            s += fit32(p);
        end
        u = 64'(fit32(s));
        return u[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with new_data high for one edge; leaves new_data high for the caller.
    task automatic issue(input logic [2:0][31:0] a, input logic [2:0][31:0] b, input logic [31:0] e, input bit accept);
        exp_t x;
        va = a;
        vb = b;
        new_data = 1'b1;
        if (accept) begin
            chk("busy_before_start", 32'(busy), 32'd0);
            x.r = e;
            x.due = cyc + 4;
            q.push_back(x);
        end
        step();
        if (accept) chk("busy_after_start", 32'(busy), 32'd1);
        va = {$urandom(), $urandom(), $urandom()};
        vb = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic run(input logic [2:0][31:0] a, input logic [2:0][31:0] b, input logic [31:0] e);
        issue(a, b, e, 1'b1);
        new_data = 1'b0;
        repeat (3) step();
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom() >> $urandom_range(0, 31);
        return $urandom_range(0, 1) ? -v : v;
    endfunction

    // Scoreboard monitor: every output_valid must match the oldest pending result at its due cycle.
    always @(negedge clk) begin
        exp_t x;
        if (output_valid) begin
            vecs++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: r=%h with nothing pending (cycle %0d)", r, cyc);
            end else begin
                x = q.pop_front();
                if (r !== x.r || cyc != x.due) begin
                    fails++;
                    $display("FAIL result: got r=%h at cycle %0d, want r=%h at cycle %0d", r, cyc, x.r, x.due);
                end
            end
        end
    end

    initial begin
        logic [2:0][31:0] a, b, c;
        logic [31:0] e;
        repeat (2) step();
        chk("reset_r", r, 32'd0);
        chk("reset_valid", 32'(output_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        step();
        run({32'h03000000, 32'h02000000, 32'h01000000}, {32'h06000000, 32'h05000000, 32'h04000000}, 32'h20000000);
`ifdef FIXED_DOT3_SATURATE_EN
        e = 32'h7FFFFFFF;
`else
        e = 32'h90000000;
`endif
        run({32'h0, 32'h64000000, 32'h64000000}, {32'h0, 32'h02000000, 32'h02000000}, e);
        run({32'h0, 32'h0, 32'hFE800000}, {32'h0, 32'h0, 32'h02000000}, 32'hFD000000);
        run({32'h0, 32'h0, 32'h00000001}, {32'h0, 32'h0, 32'h00800000}, 32'h00000000);
        run({32'h0, 32'h0, 32'hFFFFFFFF}, {32'h0, 32'h0, 32'h00800000}, 32'hFFFFFFFF);
        // new_data held through MX, MY, MZ is ignored; still high in the valid cycle starts a second one.
        a = {32'h00400000, 32'hFF000000, 32'h05000000};
        b = {32'h08000000, 32'h03000000, 32'hFE000000};
        issue(a, b, model(a, b), 1'b1);
        repeat (3) issue({$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom(), $urandom()}, 32'd0, 1'b0);
        c = {32'h01800000, 32'h00000000, 32'hFF400000};
        issue(c, a, model(c, a), 1'b1);
        new_data = 1'b0;
        repeat (3) step();
        // Reset during MY aborts the computation.
        issue(a, c, model(a, c), 1'b1);
        new_data = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        void'(q.pop_back());
        chk("abort_r", r, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(output_valid), 32'd0);
        run(b, c, model(b, c));
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) begin
                a[k] = rnd_op();
                b[k] = rnd_op();
            end
            issue(a, b, model(a, b), 1'b1);
            new_data = 1'b0;
            repeat (2) step();
            repeat ($urandom_range(1, 3)) step();
        end
        repeat (6) step();
        vecs++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
